// File: rtl/po_pad_bank_pkg.sv
// ---------------------------------------------------------------------------
// po_pad_pkg
// Shared definitions for the programmable output pad bank.
//   - po_mode_t        : 2-bit per-channel output path select
//   - PO_MODE_*        : mode encodings (bypass / registered / pipelined / hold)
//   - PO_PIPE_DEPTH_MAX: deepest pipeline a channel may be built with
// ---------------------------------------------------------------------------
package po_pad_pkg;

    typedef logic [1:0] po_mode_t;

    localparam po_mode_t PO_MODE_BYPASS = 2'b00;
    localparam po_mode_t PO_MODE_REG    = 2'b01;
    localparam po_mode_t PO_MODE_PIPE   = 2'b10;
    localparam po_mode_t PO_MODE_HOLD   = 2'b11;

    localparam int PO_PIPE_DEPTH_MAX = 8;

endpackage : po_pad_pkg

// File: rtl/po_pad_bank_if.sv
// ---------------------------------------------------------------------------
// po_pad_bank_if
// Fabric-side bundle of the pad bank (everything except clock and reset).
//   po_bank_f2a_i          fabric data, one bit per channel
//   po_bank_mode_cfg       static mode bits, channel k uses [2k+1:2k]
//   po_bank_load           per-channel hold capture strobe
//   po_bank_scan_en        global scan-shift enable
//   po_bank_sc_in          scan serial input
//   po_bank_sc_out         scan serial output
//   gfpga_pad_poutput_F2A  pad outputs
//   po_bank_parity         registered XOR of pad outputs (PO_PAD_BANK_PARITY_EN)
// Modports: master = fabric/driver side, slave = the pad bank.
// ---------------------------------------------------------------------------
interface po_pad_bank_if #(
    parameter int NUM_CH = 8
);
    logic [NUM_CH-1:0]   po_bank_f2a_i;
    logic [2*NUM_CH-1:0] po_bank_mode_cfg;
    logic [NUM_CH-1:0]   po_bank_load;
    logic                po_bank_scan_en;
    logic                po_bank_sc_in;
    logic                po_bank_sc_out;
    logic [NUM_CH-1:0]   gfpga_pad_poutput_F2A;
`ifdef PO_PAD_BANK_PARITY_EN
    logic                po_bank_parity;
`endif

    modport master (
        output po_bank_f2a_i, po_bank_mode_cfg, po_bank_load,
               po_bank_scan_en, po_bank_sc_in,
        input  po_bank_sc_out, gfpga_pad_poutput_F2A
`ifdef PO_PAD_BANK_PARITY_EN
        , input po_bank_parity
`endif
    );

    modport slave (
        input  po_bank_f2a_i, po_bank_mode_cfg, po_bank_load,
               po_bank_scan_en, po_bank_sc_in,
        output po_bank_sc_out, gfpga_pad_poutput_F2A
`ifdef PO_PAD_BANK_PARITY_EN
        , output po_bank_parity
`endif
    );

endinterface : po_pad_bank_if

// File: rtl/po_pad_bank_chan.sv
// ---------------------------------------------------------------------------
// po_pad_chan
// One output pad channel: PIPE_DEPTH stage registers, a hold register and
// the output path mux.
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_f2a            fabric data bit
//   i_mode           output path select (po_mode_t)
//   i_load           hold capture strobe
//   i_scan_en        scan-shift enable
//   i_sc_prev        scan input (previous channel's stage1 or chain input)
//   o_stage1         first stage register, doubles as scan output
//   o_pad            pad output
// ---------------------------------------------------------------------------
module po_pad_chan
    import po_pad_pkg::*;
#(
    parameter int PIPE_DEPTH = 3
) (
    input  logic     i_clk,
    input  logic     i_rst_n,
    input  logic     i_f2a,
    input  po_mode_t i_mode,
    input  logic     i_load,
    input  logic     i_scan_en,
    input  logic     i_sc_prev,
    output logic     o_stage1,
    output logic     o_pad
);
    // r_stage[0] is stage1, r_stage[PIPE_DEPTH-1] is the last pipeline stage.
    logic [PIPE_DEPTH-1:0] r_stage;
    logic                  r_hold;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stage <= '0;
            r_hold  <= 1'b0;
        end else if (i_scan_en) begin
            // Only stage1 is on the chain; deeper stages and hold freeze,
            // and a concurrent load is ignored.
            r_stage[0] <= i_sc_prev;
        end else begin
            // Stages advance in every mode so a mode switch needs no warm-up.
            r_stage <= {r_stage[PIPE_DEPTH-2:0], i_f2a};
            if (i_load) begin
                r_hold <= i_f2a;
            end
        end
    end

    // Mode change is purely combinational; pipeline contents are not flushed.
    always_comb begin
        o_pad = i_f2a;
        case (i_mode)
            PO_MODE_BYPASS: o_pad = i_f2a;
            PO_MODE_REG:    o_pad = r_stage[0];
            PO_MODE_PIPE:   o_pad = r_stage[PIPE_DEPTH-1];
            PO_MODE_HOLD:   o_pad = r_hold;
            default:        o_pad = i_f2a;
        endcase
    end

    assign o_stage1 = r_stage[0];

endmodule : po_pad_chan

// File: rtl/po_pad_bank.sv
// ---------------------------------------------------------------------------
// po_pad_bank
// NUM_CH programmable output pads between fabric F2A nets and GPOUT pads.
// Each channel selects bypass, registered, PIPE_DEPTH-stage pipelined or
// strobe-captured hold output. A scan chain threads stage1 of every channel,
// channel 0 first.
//   po_bank_clk      clock for all channel registers
//   po_bank_reset_n  asynchronous active-low reset (release synchronised
//                    upstream by the integrator)
//   bus              po_pad_bank_if.slave, data/config/scan/pad signals
// Optional build macro: PO_PAD_BANK_PARITY_EN adds bus.po_bank_parity, the
// XOR of all pad outputs registered on po_bank_clk (one cycle behind pads).
// Parameters: NUM_CH (8), PIPE_DEPTH (3, legal 2..PO_PIPE_DEPTH_MAX).
// ---------------------------------------------------------------------------
module po_pad_bank
    import po_pad_pkg::*;
#(
    parameter int NUM_CH     = 8,
    parameter int PIPE_DEPTH = 3
) (
    input  logic         po_bank_clk,
    input  logic         po_bank_reset_n,
    po_pad_bank_if.slave bus
);
    // w_sc_chain[k] feeds channel k; w_sc_chain[NUM_CH] is the chain output.
    logic [NUM_CH:0]   w_sc_chain;
    logic [NUM_CH-1:0] w_pad;

    assign w_sc_chain[0] = bus.po_bank_sc_in;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
        po_pad_chan #(
            .PIPE_DEPTH (PIPE_DEPTH)
        ) u_chan (
            .i_clk     (po_bank_clk),
            .i_rst_n   (po_bank_reset_n),
            .i_f2a     (bus.po_bank_f2a_i[gi]),
            .i_mode    (po_mode_t'(bus.po_bank_mode_cfg[2*gi +: 2])),
            .i_load    (bus.po_bank_load[gi]),
            .i_scan_en (bus.po_bank_scan_en),
            .i_sc_prev (w_sc_chain[gi]),
            .o_stage1  (w_sc_chain[gi+1]),
            .o_pad     (w_pad[gi])
        );
    end

    assign bus.gfpga_pad_poutput_F2A = w_pad;
    assign bus.po_bank_sc_out        = w_sc_chain[NUM_CH];

`ifdef PO_PAD_BANK_PARITY_EN
    logic r_parity;

    // Updates every edge, scan included, from whatever the pads show.
    always_ff @(posedge po_bank_clk or negedge po_bank_reset_n) begin
        if (!po_bank_reset_n) begin
            r_parity <= 1'b0;
        end else begin
            r_parity <= ^w_pad;
        end
    end

    assign bus.po_bank_parity = r_parity;
`endif

endmodule : po_pad_bank

// File: tb/tb_po_pad_bank.sv
module tb_po_pad_bank;

    localparam int NUM_CH     = 8;
    localparam int PIPE_DEPTH = 3;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    po_pad_bank_if #(.NUM_CH(NUM_CH)) bus ();

    po_pad_bank #(
        .NUM_CH     (NUM_CH),
        .PIPE_DEPTH (PIPE_DEPTH)
    ) dut (
        .po_bank_clk     (clk),
        .po_bank_reset_n (rst_n),
        .bus             (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n                 = 1'b0;
        bus.po_bank_f2a_i     = 8'hA5;
        bus.po_bank_mode_cfg  = 16'h5555;
        bus.po_bank_load      = 8'h00;
        bus.po_bank_scan_en   = 1'b0;
        bus.po_bank_sc_in     = 1'b0;
        #3;
        tick();
        checks++;
        if (bus.gfpga_pad_poutput_F2A !== 8'h00) begin
            errors++;
            $display("FAIL reset_reg_out got %h want %h", bus.gfpga_pad_poutput_F2A, 8'h00);
        end
        checks++;
        if (bus.po_bank_sc_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_sc_out got %b want 0", bus.po_bank_sc_out);
        end
        bus.po_bank_mode_cfg = 16'h0000;
        #1;
        checks++;
        if (bus.gfpga_pad_poutput_F2A !== 8'hA5) begin
            errors++;
            $display("FAIL reset_bypass_out got %h want %h", bus.gfpga_pad_poutput_F2A, 8'hA5);
        end
        $display("reset: reg out 00, bypass follows A5 during reset");
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_latency();
        // ch0 bypass, ch1 registered, ch2 pipelined, rest bypass
        bus.po_bank_mode_cfg = 16'h0024;
        bus.po_bank_f2a_i    = 8'h00;
        repeat (4) tick();
        bus.po_bank_f2a_i = 8'h07;
        #1;
        checks++;
        if ((bus.gfpga_pad_poutput_F2A & 8'h07) !== 8'h01) begin
            errors++;
            $display("FAIL lat_t0 got %h want %h", bus.gfpga_pad_poutput_F2A & 8'h07, 8'h01);
        end
        tick();
        bus.po_bank_f2a_i = 8'h00;
        #1;
        checks++;
        if ((bus.gfpga_pad_poutput_F2A & 8'h07) !== 8'h02) begin
            errors++;
            $display("FAIL lat_t1 got %h want %h", bus.gfpga_pad_poutput_F2A & 8'h07, 8'h02);
        end
        tick();
        checks++;
        if ((bus.gfpga_pad_poutput_F2A & 8'h07) !== 8'h00) begin
            errors++;
            $display("FAIL lat_t2 got %h want %h", bus.gfpga_pad_poutput_F2A & 8'h07, 8'h00);
        end
        tick();
        checks++;
        if ((bus.gfpga_pad_poutput_F2A & 8'h07) !== 8'h04) begin
            errors++;
            $display("FAIL lat_t3 got %h want %h", bus.gfpga_pad_poutput_F2A & 8'h07, 8'h04);
        end
        tick();
        checks++;
        if ((bus.gfpga_pad_poutput_F2A & 8'h07) !== 8'h00) begin
            errors++;
            $display("FAIL lat_t4 got %h want %h", bus.gfpga_pad_poutput_F2A & 8'h07, 8'h00);
        end
        $display("latency: bypass 0, reg 1, pipe 3 cycles, one-cycle pulses");
    endtask

    task automatic test_hold();
        bus.po_bank_mode_cfg = 16'hFFFF;
        bus.po_bank_f2a_i    = 8'h3C;
        bus.po_bank_load     = 8'hFF;
        tick();
        bus.po_bank_load  = 8'h00;
        bus.po_bank_f2a_i = 8'hC3;
        #1;
        checks++;
        if (bus.gfpga_pad_poutput_F2A !== 8'h3C) begin
            errors++;
            $display("FAIL hold_capture got %h want %h", bus.gfpga_pad_poutput_F2A, 8'h3C);
        end
        repeat (10) tick();
        checks++;
        if (bus.gfpga_pad_poutput_F2A !== 8'h3C) begin
            errors++;
            $display("FAIL hold_keep got %h want %h", bus.gfpga_pad_poutput_F2A, 8'h3C);
        end
        bus.po_bank_load = 8'h01;
        tick();
        bus.po_bank_load = 8'h00;
        #1;
        checks++;
        if (bus.gfpga_pad_poutput_F2A !== 8'h3D) begin
            errors++;
            $display("FAIL hold_partial got %h want %h", bus.gfpga_pad_poutput_F2A, 8'h3D);
        end
        $display("hold: captured 3C, kept 10 edges, partial load gives 3D");
    endtask

    task automatic test_scan();
        logic [7:0] pattern;
        pattern = 8'b1011_0010;   // shifted MSB first: 1,0,1,1,0,0,1,0
        // Preload every stage with 5A in pipelined mode.
        bus.po_bank_mode_cfg = 16'hAAAA;
        bus.po_bank_f2a_i    = 8'h5A;
        repeat (4) tick();
        checks++;
        if (bus.gfpga_pad_poutput_F2A !== 8'h5A) begin
            errors++;
            $display("FAIL scan_preload got %h want %h", bus.gfpga_pad_poutput_F2A, 8'h5A);
        end
        bus.po_bank_scan_en = 1'b1;
        bus.po_bank_load    = 8'hFF;
        bus.po_bank_f2a_i   = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            bus.po_bank_sc_in = pattern[7-i];
            tick();
            if (i == 6) begin
                checks++;
                if (bus.po_bank_sc_out !== 1'b0) begin
                    errors++;
                    $display("FAIL scan_edge7 got %b want 0", bus.po_bank_sc_out);
                end
            end
        end
        checks++;
        if (bus.po_bank_sc_out !== 1'b1) begin
            errors++;
            $display("FAIL scan_edge8 got %b want 1", bus.po_bank_sc_out);
        end
        checks++;
        if (bus.gfpga_pad_poutput_F2A !== 8'h5A) begin
            errors++;
            $display("FAIL scan_stage3_frozen got %h want %h", bus.gfpga_pad_poutput_F2A, 8'h5A);
        end
        bus.po_bank_mode_cfg = 16'h5555;
        #1;
        checks++;
        if (bus.gfpga_pad_poutput_F2A !== 8'hB2) begin
            errors++;
            $display("FAIL scan_stage1 got %h want %h", bus.gfpga_pad_poutput_F2A, 8'hB2);
        end
        bus.po_bank_mode_cfg = 16'hFFFF;
        #1;
        checks++;
        if (bus.gfpga_pad_poutput_F2A !== 8'h3D) begin
            errors++;
            $display("FAIL scan_hold_frozen got %h want %h", bus.gfpga_pad_poutput_F2A, 8'h3D);
        end
        bus.po_bank_load = 8'h00;
        $display("scan: sc_out 1 after 8 edges, stage1 B2, stage3 5A, hold 3D");
    endtask

    task automatic test_reset_mid_scan();
        bus.po_bank_mode_cfg = 16'h5555;
        bus.po_bank_sc_in    = 1'b1;
        repeat (8) tick();
        checks++;
        if (bus.po_bank_sc_out !== 1'b1 || bus.gfpga_pad_poutput_F2A !== 8'hFF) begin
            errors++;
            $display("FAIL rscan_fill got %b/%h want 1/FF", bus.po_bank_sc_out, bus.gfpga_pad_poutput_F2A);
        end
        repeat (4) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.po_bank_sc_out !== 1'b0 || bus.gfpga_pad_poutput_F2A !== 8'h00) begin
            errors++;
            $display("FAIL rscan_async got %b/%h want 0/00", bus.po_bank_sc_out, bus.gfpga_pad_poutput_F2A);
        end
        tick();
        rst_n             = 1'b1;
        bus.po_bank_sc_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (bus.po_bank_sc_out !== 1'b0) begin
                errors++;
                $display("FAIL rscan_shift%0d got %b want 0", i, bus.po_bank_sc_out);
            end
        end
        bus.po_bank_scan_en  = 1'b0;
        bus.po_bank_mode_cfg = 16'hFFFF;
        #1;
        checks++;
        if (bus.gfpga_pad_poutput_F2A !== 8'h00) begin
            errors++;
            $display("FAIL rscan_hold_cleared got %h want %h", bus.gfpga_pad_poutput_F2A, 8'h00);
        end
        $display("reset mid-scan: chain and hold cleared, zeros shift out");
    endtask

`ifdef PO_PAD_BANK_PARITY_EN
    task automatic test_parity();
        bus.po_bank_scan_en  = 1'b0;
        bus.po_bank_mode_cfg = 16'h5555;
        bus.po_bank_f2a_i    = 8'h00;
        repeat (3) tick();
        bus.po_bank_f2a_i = 8'h01;
        tick();
        checks++;
        if (bus.po_bank_parity !== 1'b0) begin
            errors++;
            $display("FAIL parity_01_e1 got %b want 0", bus.po_bank_parity);
        end
        tick();
        checks++;
        if (bus.po_bank_parity !== 1'b1) begin
            errors++;
            $display("FAIL parity_01_e2 got %b want 1", bus.po_bank_parity);
        end
        bus.po_bank_f2a_i = 8'h03;
        tick();
        checks++;
        if (bus.po_bank_parity !== 1'b1) begin
            errors++;
            $display("FAIL parity_03_e1 got %b want 1", bus.po_bank_parity);
        end
        tick();
        checks++;
        if (bus.po_bank_parity !== 1'b0) begin
            errors++;
            $display("FAIL parity_03_e2 got %b want 0", bus.po_bank_parity);
        end
        $display("parity: 01 -> 1 and 03 -> 0 two edges after change");
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_latency();
        test_hold();
        test_scan();
        test_reset_mid_scan();
`ifdef PO_PAD_BANK_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_po_pad_bank

// File: doc/po_pad_bank.md
Name: po_pad_bank

Overview:
- Parametrised successor to the single-channel programmable output pad: NUM_CH output pads in one logical tile.
- Each channel picks its output path from per-channel configuration bits: bypass, single register, PIPE_DEPTH-stage pipeline, or strobe-captured hold.
- A scan chain runs through the first register stage of every channel.
- Sits between fabric F2A nets and the GPOUT pad ports of an IO tile.

Parameters:
- NUM_CH, 8, number of output pad channels.
- PIPE_DEPTH, 3, register stages in pipelined mode (min 2, max 8).

Ports:
- po_bank_clk  input  1  single clock for all channel registers.
- po_bank_reset_n  input  1  asynchronous, active-low reset.
- po_bank_f2a_i  input  NUM_CH  fabric data, one bit per channel.
- po_bank_mode_cfg  input  2*NUM_CH  static mode bits; channel k uses bits [2k+1:2k].
- po_bank_load  input  NUM_CH  per-channel capture strobe for hold mode.
- po_bank_scan_en  input  1  global scan-shift enable.
- po_bank_sc_in  input  1  scan chain serial input.
- po_bank_sc_out  output  1  scan chain serial output.
- gfpga_pad_poutput_F2A  output  NUM_CH  pad outputs.

Behaviour:
- Clock and reset: one clock (po_bank_clk); reset is asynchronous and active-low (po_bank_reset_n).
- Reset: all stage registers and hold registers clear to 0, so sc_out = 0. Registered, pipelined and hold outputs read 0. Bypass outputs follow f2a_i combinationally, even during reset.
- Per-channel register state: stage[1..PIPE_DEPTH] and hold_q.
- Mode 2'b00, bypass: out = f2a_i, 0-cycle latency.
- Mode 2'b01, registered: out = stage1, 1-cycle latency.
- Mode 2'b10, pipelined: out = stage[PIPE_DEPTH], PIPE_DEPTH-cycle latency.
- Mode 2'b11, hold: out = hold_q.
  - hold_q <= f2a_i on any edge where load[k]=1 and scan_en=0; otherwise it holds.
- Normal operation (scan_en=0), every edge:
  - stage1 <= f2a_i.
  - stage[i] <= stage[i-1] for i = 2..PIPE_DEPTH.
  - Stages run in every mode so that a mode switch needs no warm-up.
- Scan (scan_en=1):
  - ch0.stage1 <= sc_in.
  - ch[k].stage1 <= ch[k-1].stage1 for k = 1..NUM_CH-1.
  - Stages 2..PIPE_DEPTH and hold_q keep their values; load is ignored.
  - sc_out = ch[NUM_CH-1].stage1, a direct register output.
  - Scan latency from sc_in to sc_out is NUM_CH edges.
- Mode change:
  - Takes effect on the output mux immediately (combinational).
  - Pipeline contents are not flushed; the output shows whatever the selected stage currently holds.
- Simultaneous events:
  - load and scan_en together: scan wins, hold_q is unchanged.
  - Reset asserted mid-scan: chain clears, and shifting resumes from all zeros on the first edge after release.
- Reset release: synchronous to po_bank_clk is not required of this block; the integrator synchronises release upstream.
- Widths: no arithmetic; every datapath is 1 bit per channel.

Optional Feature:
- Macro: PO_PAD_BANK_PARITY_EN.
- With the macro defined:
  - Extra output po_bank_parity, 1 bit, equal to the XOR of all NUM_CH gfpga_pad_poutput_F2A bits, registered on po_bank_clk.
  - Parity register resets to 0 and updates every edge, including during scan.
  - Adds 1 cycle of latency relative to the outputs.
- Without the macro: the port and its register are absent, and the rest of the behaviour is identical.

Decomposition:
- Shared package po_pad_pkg:
  - Mode encoding constants PO_MODE_BYPASS=2'b00, PO_MODE_REG=2'b01, PO_MODE_PIPE=2'b10, PO_MODE_HOLD=2'b11.
  - Typedef po_mode_t (2-bit).
  - Constant PO_PIPE_DEPTH_MAX=8.
- One sub-module: po_pad_chan, a single channel holding the stage registers, hold register and output mux. It takes sc_prev as its scan input and exposes stage1 as its scan output.
- The top generates NUM_CH instances and links the scan chain between them.

Test Plan:
- Reset: hold reset_n=0 with f2a=8'hA5, all modes 2'b01 -> outputs 8'h00 and sc_out=0. With all modes 2'b00 -> outputs 8'hA5 while reset is still asserted.
- Latency: ch0=bypass, ch1=reg, ch2=pipe (PIPE_DEPTH=3); pulse f2a=8'h07 for one cycle at edge T -> ch0 high in the same cycle, ch1 high after T+1, ch2 high after T+3, each for exactly one cycle.
- Hold: all channels in hold mode; f2a=8'h3C with load=8'hFF for one edge, then f2a=8'hC3 with load=0 for 10 edges -> outputs stay 8'h3C. load=8'h01 with f2a=8'hC3 -> output 8'h3D.
- Scan: scan_en=1, shift pattern 1,0,1,1,0,0,1,0 into sc_in over 8 edges -> sc_out shows the first bit (1) after edge 8. Hold registers and stages 2..3 are unchanged; a concurrent load=8'hFF has no effect.
- Async reset mid-scan: assert reset_n=0 between edges 4 and 5 of a shift -> sc_out=0 immediately. After release, 8 shift edges of zeros keep sc_out=0.
- PO_PAD_BANK_PARITY_EN: f2a=8'h01 in reg mode -> parity=1 two edges after the f2a change. f2a=8'h03 -> parity=0 two edges later.
